// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: single-port byte-enabled RAM controller with auto-sleep and timed wake-up.
module sp_ram_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WORDS   = 4096,
  parameter int OUT_REG     = 0,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  input  logic                    sleep_en_i,
  output logic                    sleep_o
);
  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int MW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_t;
  state_t                     state, state_nx;
  logic [7:0]                 idle_cnt, idle_nx, wake_cnt, wake_nx;
  logic [DATA_WIDTH-1:0]      mem [NUM_WORDS];
  logic [ADDR_WIDTH-OFF-1:0]  idx;
  logic [MW-1:0]              midx;
  logic                       in_range, idle_inc, pending, unused_addr;
  logic                       s1_valid, s1_err;
  logic [DATA_WIDTH-1:0]      s1_data, rd_word;
  assign idx         = addr_i[ADDR_WIDTH-1:OFF];
  assign midx        = idx[MW-1:0];
  assign in_range    = 64'(idx) < 64'(NUM_WORDS);
  assign unused_addr = ^addr_i[OFF-1:0];
  assign rd_word     = in_range ? mem[midx] : '0;
  // Reset gates the grant so nothing is accepted (or written) while rst_n is low.
  assign gnt_o       = req_i & rst_n & (state == ACTIVE);
  assign sleep_o     = state == SLEEP;
  assign idle_inc    = (state == ACTIVE) && !req_i && sleep_en_i && !pending;
  always_ff @(posedge clk)
    if (gnt_o && we_i && in_range)
      for (int b = 0; b < BW; b++)
        if (be_i[b]) mem[midx][8*b +: 8] <= wdata_i[8*b +: 8];
  always_comb begin
    state_nx = state;
    wake_nx  = wake_cnt;
    idle_nx  = !idle_inc ? 8'd0 : (&idle_cnt) ? idle_cnt : idle_cnt + 8'd1;
    case (state)
      ACTIVE: state_nx = (idle_inc && idle_cnt == 8'(IDLE_CYCLES - 1)) ? SLEEP : ACTIVE;
      SLEEP: begin
        state_nx = (req_i || !sleep_en_i) ? WAKE : SLEEP;
        wake_nx  = (req_i || !sleep_en_i) ? 8'(WAKE_CYCLES) : wake_cnt;
      end
      WAKE: begin
        state_nx = (wake_cnt <= 8'd1) ? ACTIVE : WAKE;
        wake_nx  = (wake_cnt <= 8'd1) ? 8'd0 : wake_cnt - 8'd1;
      end
      default: state_nx = ACTIVE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_nx;
      wake_cnt <= wake_nx;
      s1_valid <= gnt_o;
      s1_err   <= gnt_o & ~in_range;
      if (gnt_o && !we_i) s1_data <= rd_word;
    end
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  v2, e2;
      logic [DATA_WIDTH-1:0] d2;
      // s1_data only moves on read grants, so d2 only moves on read responses.
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v2 <= 1'b0;
          e2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= s1_valid;
          e2 <= s1_valid & s1_err;
          d2 <= s1_data;
        end
      assign rvalid_o = v2;
      assign err_o    = e2;
      assign rdata_o  = d2;
      assign pending  = s1_valid | v2;
    end else begin : g_no_reg
      assign rvalid_o = s1_valid;
      assign err_o    = s1_err;
      assign rdata_o  = s1_data;
      assign pending  = s1_valid;
    end
  endgenerate
endmodule

// File: doc/sp_ram_ctrl.md
SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; legal values 32, 64, 128.
REQ-003 SHALL have parameter NUM_WORDS, default 4096, storage depth in words; need not be a power of two.
REQ-004 SHALL have parameter OUT_REG, default 0, extra read-output register stage; legal values 0 or 1.
REQ-005 SHALL have parameter IDLE_CYCLES, default 16, idle cycles required before sleep entry; legal range 1..255.
REQ-006 SHALL have parameter WAKE_CYCLES, default 4, wake-up delay in cycles; legal range 1..255.
REQ-007 SHALL have a single clock; reset is asynchronous and active-low.
REQ-008 SHALL have the following ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  DATA_WIDTH/8  byte enables, active-high.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_WIDTH  read data.
- err_o  out  1  out-of-range error, qualified by rvalid_o.
- sleep_en_i  in  1  permits automatic sleep.
- sleep_o  out  1  storage in retention sleep.

Function
REQ-009 SHALL compute word index as addr_i[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits are ignored.
REQ-010 SHALL implement states ACTIVE, SLEEP and WAKE.
REQ-011 SHALL drive gnt_o = req_i AND (state == ACTIVE), combinationally.
REQ-012 SHALL accept one access per granted cycle, back-to-back, with no bubbles.
REQ-013 SHALL, on a granted in-range write, update only the bytes whose be_i bit is 1; be_i = 0 writes nothing but still responds.
REQ-014 SHALL assert rvalid_o for exactly one cycle, 1+OUT_REG cycles after each grant, for reads and writes alike, in grant order.
REQ-015 SHALL update rdata_o only on read responses and hold its value otherwise.
REQ-016 SHALL treat a word index >= NUM_WORDS as out of range: writes are suppressed, read data is all-zero, and err_o = 1 together with that rvalid_o.
REQ-017 SHALL hold err_o at 0 whenever rvalid_o = 0.
REQ-018 SHALL keep an idle counter, 8-bit, saturating, that:
- increments in ACTIVE when req_i = 0, sleep_en_i = 1 and no response is pending;
- clears otherwise.
REQ-019 SHALL transition ACTIVE -> SLEEP on the clock edge where the idle counter equals IDLE_CYCLES-1 and the increment condition holds.
REQ-020 SHALL assert sleep_o = 1 exactly while in SLEEP, and SHALL retain memory contents in SLEEP.
REQ-021 SHALL transition SLEEP -> WAKE when req_i = 1 or sleep_en_i = 0, loading the wake counter with WAKE_CYCLES.
REQ-022 SHALL decrement the wake counter in WAKE and SHALL transition to ACTIVE when it reaches 1; gnt_o is 0 throughout SLEEP and WAKE.
REQ-023 SHALL require the master to hold req_i and its attributes stable until gnt_o; an unsustained request is ignored, with no error.
REQ-024 SHALL NOT enter SLEEP while any response is in flight.

Reset
REQ-025 SHALL, on rst_n = 0, immediately set:
- state = ACTIVE;
- idle and wake counters = 0;
- gnt_o, rvalid_o and err_o = 0;
- sleep_o = 0;
- rdata_o = 0.
REQ-026 SHALL discard in-flight responses on reset; memory contents are undefined after power-up and unchanged by reset.
REQ-027 SHALL allow gnt_o in the first cycle after rst_n deasserts.

Verification
REQ-028 Write 0xDEADBEEF to 0x0010 with be=0xF, then write 0x000000AA with be=0x1, then read 0x0010 -> rdata_o = 0xDEADBEAA; rvalid at grant+1 (OUT_REG=0) and grant+2 (OUT_REG=1).
REQ-029 Four back-to-back reads at 0x0,0x4,0x8,0xC with req held -> gnt_o high 4 consecutive cycles, 4 consecutive rvalid pulses in order.
REQ-030 NUM_WORDS=4096, read then write at byte address 0x4000 -> err_o = 1 on both responses, read data 0, subsequent read of word 0 unchanged.
REQ-031 sleep_en_i=1, IDLE_CYCLES=16, no requests -> sleep_o rises after 16 idle cycles; req_i then -> gnt_o = 0 for WAKE_CYCLES+1 cycles, then grant; data written before sleep reads back intact.
REQ-032 Grant a read, assert rst_n = 0 before its response -> no rvalid_o, all outputs 0, state ACTIVE, next request granted immediately after release.
REQ-033 sleep_en_i=0 for 100 idle cycles -> sleep_o stays 0; sleep_en_i dropped while in SLEEP -> WAKE then ACTIVE with no request.
